param_pattern_detector: RTL and testbench
=========================================

Name: param_pattern_detector

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed-pattern detector. Samples a qualified serial bit stream and compares it against a runtime-loadable pattern of PAT_LEN bits. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. Sits on serial front-end links as a sync-word and marker detector.

Parameters:
PAT_LEN, 4, pattern length in bits (2..32)
PAT_RESET, 4'b1011, pattern value loaded at reset; MSB is the first bit received
CNT_W, 8, match counter width

Ports:
clk  in  1  clock, rising-edge active
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_bit qualifier; a bit is accepted only on edges with in_valid=1
in_bit  in  1  serial data bit
overlap_en  in  1  1 = overlapping matches allowed; 0 = non-overlapping
pat_load  in  1  single-cycle strobe; captures pat_in
pat_in  in  PAT_LEN  new pattern value
cnt_clr  in  1  clears match_count
detected  out  1  registered one-cycle pulse per match
match_count  out  CNT_W  number of matches, saturating
count_sat  out  1  high while match_count is all-ones

Behaviour:
- Reset (sync, active-high) state: pattern=PAT_RESET, history=0, fill=0, detected=0, match_count=0, count_sat=0. Reset overrides all other inputs.
- Accepted bit: history <= {history[PAT_LEN-2:0], in_bit}, so the newest bit is in the LSB. fill increments, saturating at PAT_LEN.
- Fill state machine, encoded by fill:
  - EMPTY (fill=0) -> FILLING on an accepted bit.
  - FILLING (0<fill<PAT_LEN) -> ARMED when fill reaches PAT_LEN.
  - ARMED: a compare is made on every accepted bit.
- Match condition: the next history value equals pattern, the bit is accepted this edge, and fill (including this bit) equals PAT_LEN. Partial history never matches.
- Latency: detected is high for exactly the one cycle after the edge that accepted the completing bit. detected=0 on any cycle without a match, including in_valid=0 cycles.
- Overlap mode (overlap_en=1): after a match, fill stays at PAT_LEN, so trailing bits can start the next match.
- Non-overlap mode (overlap_en=0): after a match, fill <= 0 and history <= 0. The next match needs PAT_LEN fresh bits.
- overlap_en is sampled on the match edge; changing it mid-stream has no other effect.
- Pattern load: when pat_load=1, pattern <= pat_in, history <= 0 and fill <= 0.
  - Any bit offered on the same edge is discarded.
  - No match can fire on that edge.
  - match_count is unaffected.
- Match counter:
  - Increments on each match.
  - Holds at 2^CNT_W-1 (no wrap).
  - count_sat is registered from the next count value, so it is coherent with match_count.
- Simultaneous events:
  - cnt_clr with a match gives match_count=1 (clear first, then count). detected still pulses.
  - pat_load with cnt_clr: both take effect.
  - in_valid=0 with in_bit toggling: no state change.

Optional Feature:
Macro PATTERN_MASK_EN.
- Defined: extra input pat_mask_in [PAT_LEN-1:0] is captured together with pat_in on pat_load; reset value is all-ones. A mask bit of 0 makes the matching pattern position don't-care. The match compares (history ^ pattern) & mask == 0. An all-zero mask matches on every accepted bit once ARMED.
- Not defined: no port, no register; every bit must match exactly.

Test Plan:
1. Defaults, overlap_en=1, valid every cycle, bits 1,0,1,1,0,1,1 -> detected pulses after the 4th and 7th bits; match_count=2.
2. Same stream with overlap_en=0 -> single pulse after the 4th bit; bits 5-7 leave fill=3 with no detect; match_count=1.
3. Stream 1,0,1,1 with in_valid=0 for 3 cycles between bits 2 and 3 (in_bit toggling while invalid) -> one pulse, one cycle after the 4th valid bit; no pulse during the gaps.
4. Bits 1,0,1, then pat_load with pat_in=4'b0110 (bit offered the same cycle is discarded), then 1 -> no detect. Then 0,1,1,0 -> detect after the final 0.
5. CNT_W=2, overlap mode, stream 1,0,1,1,0,1,1,0,1,1,0,1,1 -> 4 pulses; match_count=3 with count_sat=1 after the 3rd match and stays there. Then cnt_clr on the same cycle as a match -> match_count=1, count_sat=0.
6. Assert reset mid-pattern after bits 1,0,1, then feed 1 -> no detect. Then 1,0,1,1 -> detect; all outputs are 0 on the cycle after reset.

Source files
------------

// File: rtl/param_pattern_detector.sv
// param_pattern_detector: serial bit-pattern detector with a runtime-loadable
// PAT_LEN-bit pattern, overlapping/non-overlapping match modes and a
// saturating match counter.
// Optional feature macro: PATTERN_MASK_EN (adds pat_mask_in; a mask bit of 0
// makes that pattern position don't-care).
module param_pattern_detector #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap_en,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`ifdef PATTERN_MASK_EN
    input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
    input  logic               cnt_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // fill counts accepted bits since the last restart; it doubles as the
    // EMPTY / FILLING / ARMED state (0 / 1..PAT_LEN-1 / PAT_LEN).
    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-1:0] history_q, history_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               detected_q, detected_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               count_sat_q, count_sat_d;
    logic [PAT_LEN-1:0] mask_eff;

    // Candidate history/fill if the offered bit is accepted this edge.
    logic [PAT_LEN-1:0] hist_shift;
    logic [FW-1:0]      fill_inc;
    logic               match;
    logic [CNT_W-1:0]   cnt_base;

    assign hist_shift = {history_q[PAT_LEN-2:0], in_bit};
    assign fill_inc   = (fill_q == FULL) ? FULL : fill_q + 1'b1;

`ifdef PATTERN_MASK_EN
    logic [PAT_LEN-1:0] mask_q, mask_d;

    // Mask register, captured alongside the pattern.
    always_ff @(posedge clk) begin
        if (reset) mask_q <= '1;
        else       mask_q <= mask_d;
    end

    // Mask next value: only a pattern load changes it.
    always_comb begin
        mask_d = mask_q;
        if (pat_load) mask_d = pat_mask_in;
    end

    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    // State register: pattern, shift history, fill state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q     <= PAT_RESET;
            history_q     <= '0;
            fill_q        <= '0;
            detected_q    <= 1'b0;
            match_count_q <= '0;
            count_sat_q   <= 1'b0;
        end else begin
            pattern_q     <= pattern_d;
            history_q     <= history_d;
            fill_q        <= fill_d;
            detected_q    <= detected_d;
            match_count_q <= match_count_d;
            count_sat_q   <= count_sat_d;
        end
    end

    // Next-state: a load restarts the stream (and swallows any offered bit);
    // a non-overlap match also restarts it; otherwise accepted bits shift in.
    always_comb begin
        pattern_d = pattern_q;
        history_d = history_q;
        fill_d    = fill_q;
        if (pat_load) begin
            pattern_d = pat_in;
            history_d = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            if (match && !overlap_en) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = hist_shift;
                fill_d    = fill_inc;
            end
        end
    end

    // Output logic: match only on an accepted bit that completes a full
    // window; the counter clears before counting so clear+match yields 1.
    always_comb begin
        match         = in_valid && !pat_load && (fill_inc == FULL) &&
                        (((hist_shift ^ pattern_q) & mask_eff) == '0);
        detected_d    = match;
        cnt_base      = cnt_clr ? '0 : match_count_q;
        match_count_d = cnt_base;
        if (match && !(&cnt_base)) match_count_d = cnt_base + 1'b1;
        count_sat_d   = &match_count_d;
    end

    assign detected    = detected_q;
    assign match_count = match_count_q;
    assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_param_pattern_detector.sv
// Bench for param_pattern_detector: a default instance (CNT_W=8) and a
// CNT_W=2 instance share all inputs and are checked against a queue-based
// reference model of the detector's rules.
module tb_param_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, in_valid, in_bit, overlap_en, pat_load, cnt_clr;
    logic [3:0] pat_in;
    logic       det8, sat8, det2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    param_pattern_detector dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
`ifdef PATTERN_MASK_EN
        .pat_mask_in(4'b1111),
`endif
        .cnt_clr(cnt_clr), .detected(det8), .match_count(cnt8), .count_sat(sat8)
    );

    param_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
`ifdef PATTERN_MASK_EN
        .pat_mask_in(4'b1111),
`endif
        .cnt_clr(cnt_clr), .detected(det2), .match_count(cnt2), .count_sat(sat2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the bits accepted since the last restart, oldest first.
    bit         mq[$];
    logic [3:0] m_pat;
    int         m_c8, m_c2;
    logic       m_det;

    logic [13:0] obs_vec, exp_vec;
    assign obs_vec = {det8, cnt8, sat8, det2, cnt2, sat2};

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic apply(input logic rst, input logic v, input logic b,
                         input logic ov, input logic pl, input logic [3:0] pi,
                         input logic clr);
        logic [3:0] win;
        bit         m;
        @(negedge clk);
        reset = rst; in_valid = v; in_bit = b; overlap_en = ov;
        pat_load = pl; pat_in = pi; cnt_clr = clr;
        m = 0;
        if (rst) begin
            m_pat = 4'b1011; mq.delete(); m_c8 = 0; m_c2 = 0;
        end else begin
            if (pl) begin
                m_pat = pi; mq.delete();
            end else if (v) begin
                mq.push_back(b);
                if (mq.size() > 4) void'(mq.pop_front());
                if (mq.size() == 4) begin
                    win = {mq[0], mq[1], mq[2], mq[3]};
                    m = (win == m_pat);
                end
                if (m && !ov) mq.delete();
            end
            if (clr) begin m_c8 = 0; m_c2 = 0; end
            if (m) begin
                m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
                m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
            end
        end
        m_det = m;
        exp_vec = {m_det, 8'(m_c8), (m_c8 == 255), m_det, 2'(m_c2), (m_c2 == 3)};
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic ov);
        apply(1'b0, 1'b1, b, ov, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        vectors++;
        if (obs_vec !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs_vec, 14'd0);
        end
    endtask

    task automatic test_overlap;
        logic [6:0] s = 7'b1011011;
        int pulses = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(s[i], 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL overlap bit%0d: got %h want %h", 6 - i, obs_vec, exp_vec);
            end
            if (det8) pulses++;
        end
        vectors++;
        if (pulses != 2 || cnt8 !== 8'd2) begin
            miscompares++;
            $display("FAIL overlap_total: got pulses=%0d cnt=%0d want 2/2", pulses, cnt8);
        end
    endtask

    task automatic test_nonoverlap;
        logic [6:0] s = 7'b1011011;
        int pulses = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            bit_in(s[i], 1'b0);
            vectors++;
            if (obs_vec !== exp_vec || det8 !== (i == 3)) begin
                miscompares++;
                $display("FAIL nonoverlap bit%0d: got %h want %h", 6 - i, obs_vec, exp_vec);
            end
            if (det8) pulses++;
        end
        // bits 5-7 left three bits pending; one more 1 must not complete 1011
        bit_in(1'b1, 1'b0);
        vectors++;
        if (pulses != 1 || cnt8 !== 8'd1 || det8 !== 1'b0) begin
            miscompares++;
            $display("FAIL nonoverlap_total: got pulses=%0d cnt=%0d det=%b want 1/1/0",
                     pulses, cnt8, det8);
        end
    endtask

    task automatic test_gaps;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, i[0], 1'b1, 1'b0, 4'b0000, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec || det8 !== 1'b0) begin
                miscompares++;
                $display("FAIL gap%0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || det8 !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_detect: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_pat_load;
        logic [4:0] s = 5'b10110;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        vectors++;
        if (obs_vec !== exp_vec || det8 !== 1'b0) begin
            miscompares++;
            $display("FAIL load_edge: got %h want %h", obs_vec, exp_vec);
        end
        for (int i = 4; i >= 0; i--) begin
            bit_in(s[i], 1'b1);
            vectors++;
            if (obs_vec !== exp_vec || det8 !== (i == 0)) begin
                miscompares++;
                $display("FAIL load_bit%0d: got %h want %h", 4 - i, obs_vec, exp_vec);
            end
        end
        // load together with clear: both take effect
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || cnt8 !== 8'd0) begin
            miscompares++;
            $display("FAIL load_clr: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_saturate;
        logic [12:0] s = 13'b1011011011011;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 12; i >= 0; i--) begin
            bit_in(s[i], 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL sat_bit%0d: got %h want %h", 12 - i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (cnt2 !== 2'd3 || sat2 !== 1'b1 || cnt8 !== 8'd4) begin
            miscompares++;
            $display("FAIL sat_hold: got cnt2=%0d sat2=%b cnt8=%0d want 3/1/4", cnt2, sat2, cnt8);
        end
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || cnt2 !== 2'd1 || sat2 !== 1'b0 || det2 !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_with_match: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_sat8;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 265; i++) begin
            bit_in(1'b1, 1'b1);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL sat8_bit%0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (cnt8 !== 8'hff || sat8 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat8_hold: got cnt=%0d sat=%b want 255/1", cnt8, sat8);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] s = 4'b1011;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        vectors++;
        if (obs_vec !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h want %h", obs_vec, 14'd0);
        end
        bit_in(1'b1, 1'b1);
        vectors++;
        if (obs_vec !== exp_vec || det8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_nodet: got %h want %h", obs_vec, exp_vec);
        end
        for (int i = 3; i >= 0; i--) begin
            bit_in(s[i], 1'b1);
            vectors++;
            if (obs_vec !== exp_vec || det8 !== (i == 0)) begin
                miscompares++;
                $display("FAIL reset_mid_bit%0d: got %h want %h", 3 - i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] pi;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            pi = ($urandom_range(0, 1) == 0) ? 4'b1011 : 4'($urandom);
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 29) == 0, pi,
                  $urandom_range(0, 39) == 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random%0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap_en = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
        test_reset;
        test_overlap;
        test_nonoverlap;
        test_gaps;
        test_pat_load;
        test_saturate;
        test_sat8;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
